// File: rtl/finder_pattern_scanner.sv
// rtl/finder_pattern_scanner.sv - raster scan of a binarized frame for 1:1:3:1:1 finder-pattern runs
module finder_pattern_scanner #(
    parameter int WIDTH        = 480,
    parameter int HEIGHT       = 480,
    parameter int READ_LATENCY = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start_scan,
    input  logic         pixel_reading,
    output logic [19:0]  address_reading,
    output logic [479:0] horz_patterns,
    output logic [479:0] vert_patterns,
    output logic         patterns_valid,
    output logic         busy
);

    localparam logic [9:0]  W_LEN      = 10'(WIDTH);
    localparam logic [9:0]  H_LEN      = 10'(HEIGHT);
    localparam logic [9:0]  W_LAST     = 10'(WIDTH - 1);
    localparam logic [9:0]  H_LAST     = 10'(HEIGHT - 1);
    localparam logic [19:0] ROW_STRIDE = 20'(WIDTH);
    localparam logic [7:0]  DRAIN_LAST = 8'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN_ROWS,
        DRAIN_ROWS,
        SCAN_COLS,
        DRAIN_COLS,
        DONE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       col_pass;
        logic       first;
        logic       last;
        logic [9:0] pos;
    } issue_t;

    state_t      state, state_next;
    logic [9:0]  inner_cnt, inner_next;
    logic [9:0]  outer_cnt, outer_next;
    logic [19:0] addr_next;
    logic [7:0]  drain_cnt, drain_next;
    logic        clear_masks;
    logic [9:0]  line_last, outer_last;
    issue_t      issue;
    issue_t      pipe [READ_LATENCY];
    issue_t      resp;

    // Run tracker: r4 is the newest completed run, index 0 the oldest.
    logic                cur_col;
    logic [8:0]          cur_len;
    logic [4:0][8:0]     run_len;
    logic [4:0]          run_col;
    logic [2:0]          run_cnt;
    logic [4:0][8:0]     b_len;
    logic [4:0]          b_col;
    logic [2:0]          b_cnt;
    logic                n_col;
    logic [8:0]          n_len;
    logic [479:0]        mark;
    logic [9:0]          limit;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        inner_next     = inner_cnt;
        outer_next     = outer_cnt;
        addr_next      = address_reading;
        drain_next     = drain_cnt;
        clear_masks    = 1'b0;
        busy           = (state != IDLE);
        patterns_valid = (state == DONE);
        line_last      = (state == SCAN_COLS) ? H_LAST : W_LAST;
        outer_last     = (state == SCAN_COLS) ? W_LAST : H_LAST;
        issue.valid    = (state == SCAN_ROWS) || (state == SCAN_COLS);
        issue.col_pass = (state == SCAN_COLS);
        issue.first    = (inner_cnt == 10'd0);
        issue.last     = (inner_cnt == line_last);
        issue.pos      = inner_cnt;

        unique case (state)
            IDLE: begin
                if (start_scan) begin
                    clear_masks = 1'b1;
                    inner_next  = '0;
                    outer_next  = '0;
                    addr_next   = '0;
                    state_next  = SCAN_ROWS;
                end
            end
            SCAN_ROWS, SCAN_COLS: begin
                // Row pass walks addresses linearly; column pass strides by WIDTH.
                if (inner_cnt != line_last) begin
                    inner_next = inner_cnt + 10'd1;
                    addr_next  = issue.col_pass ? address_reading + ROW_STRIDE
                                                : address_reading + 20'd1;
                end else if (outer_cnt != outer_last) begin
                    inner_next = '0;
                    outer_next = outer_cnt + 10'd1;
                    addr_next  = issue.col_pass ? 20'(outer_cnt) + 20'd1
                                                : address_reading + 20'd1;
                end else begin
                    inner_next = '0;
                    outer_next = '0;
                    addr_next  = '0;
                    drain_next = '0;
                    state_next = issue.col_pass ? DRAIN_COLS : DRAIN_ROWS;
                end
            end
            DRAIN_ROWS, DRAIN_COLS: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = (state == DRAIN_ROWS) ? SCAN_COLS : DONE;
                end else begin
                    drain_next = drain_cnt + 8'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            inner_cnt       <= '0;
            outer_cnt       <= '0;
            address_reading <= '0;
            drain_cnt       <= '0;
        end else begin
            inner_cnt       <= inner_next;
            outer_cnt       <= outer_next;
            address_reading <= addr_next;
            drain_cnt       <= drain_next;
        end
    end

    // Issued coordinates travel alongside the frame-buffer read latency.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign resp = pipe[READ_LATENCY-1];

    function automatic logic [479:0] match_mark(
        input logic [4:0][8:0] len,
        input logic [4:0]      col,
        input logic [2:0]      cnt,
        input logic [9:0]      e,
        input logic [9:0]      lim
    );
        logic [15:0] t;
        logic [15:0] r14;
        logic        ok;
        logic [11:0] hi;
        logic [11:0] lo;
        t  = 16'(len[0]) + 16'(len[1]) + 16'(len[2]) + 16'(len[3]) + 16'(len[4]);
        ok = (cnt == 3'd5) && (col == 5'b01010) && (t >= 16'd7);
        for (int i = 0; i < 5; i++) begin
            r14 = 16'(len[i]) * 16'd14;
            if (i == 2) begin
                ok = ok && (r14 >= t * 16'd5) && (r14 <= t * 16'd7);
            end else begin
                ok = ok && (r14 >= t) && (r14 <= t * 16'd3);
            end
        end
        hi = 12'(e) - 12'(len[4]) - 12'(len[3]);
        lo = hi - 12'(len[2]) + 12'd1;
        for (int i = 0; i < 480; i++) begin
            match_mark[i] = ok && (12'(i) >= lo) && (12'(i) <= hi) && (10'(i) < lim);
        end
    endfunction

    // A colour change and a line end can both complete runs on the same pixel.
    always_comb begin
        b_len = run_len;
        b_col = run_col;
        b_cnt = run_cnt;
        n_col = cur_col;
        n_len = cur_len;
        mark  = '0;
        limit = resp.col_pass ? H_LEN : W_LEN;
        if (resp.valid) begin
            if (resp.first) begin
                b_len = '0;
                b_col = '0;
                b_cnt = '0;
                n_col = pixel_reading;
                n_len = 9'd1;
            end else if (pixel_reading != cur_col) begin
                b_len = {cur_len, b_len[4:1]};
                b_col = {cur_col, b_col[4:1]};
                b_cnt = (b_cnt == 3'd5) ? 3'd5 : b_cnt + 3'd1;
                if (!cur_col) begin
                    mark = mark | match_mark(b_len, b_col, b_cnt, resp.pos - 10'd1, limit);
                end
                n_col = pixel_reading;
                n_len = 9'd1;
            end else begin
                n_len = (cur_len == 9'd511) ? 9'd511 : cur_len + 9'd1;
            end
            if (resp.last) begin
                b_len = {n_len, b_len[4:1]};
                b_col = {n_col, b_col[4:1]};
                b_cnt = (b_cnt == 3'd5) ? 3'd5 : b_cnt + 3'd1;
                if (!n_col) begin
                    mark = mark | match_mark(b_len, b_col, b_cnt, resp.pos, limit);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cur_col       <= 1'b0;
            cur_len       <= '0;
            run_len       <= '0;
            run_col       <= '0;
            run_cnt       <= '0;
            horz_patterns <= '0;
            vert_patterns <= '0;
        end else begin
            cur_col <= n_col;
            cur_len <= n_len;
            run_len <= b_len;
            run_col <= b_col;
            run_cnt <= b_cnt;
            if (clear_masks) begin
                horz_patterns <= '0;
                vert_patterns <= '0;
            end else if (resp.col_pass) begin
                vert_patterns <= vert_patterns | mark;
            end else begin
                horz_patterns <= horz_patterns | mark;
            end
        end
    end

endmodule
